// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: bus width defaults and the
// responder FSM state encoding (also used by memory_interface).
package mem_if_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;

    // Responder FSM encoding, kept as plain constants for legacy users.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mem_responder_if.sv
// Four-phase memory request bus between an initiator (master) and the
// responder (slave).
interface mem_responder_if
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_err;
    logic              busy;

    modport master (
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack, mem_err, busy
    );

    modport slave (
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack, mem_err, busy
    );
endinterface

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM, write-first, one-cycle registered read.
// The output register can be cleared; the storage array never is.
module mem_resp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic              i_clr,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage write port; no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (i_en && i_we)
            r_mem[i_addr] <= i_wdata;
    end

    // Read register: write-first on writes, cleared on reset or rejected access,
    // otherwise holds until the next access.
    always_ff @(posedge clk) begin
        if (i_clr)
            o_rdata <= '0;
        else if (i_en)
            o_rdata <= i_we ? i_wdata : r_mem[i_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures a request on mem_cs, waits LATENCY cycles,
// performs the access and pulses mem_ack for one cycle, then holds in DONE
// until the initiator drops mem_cs (four-phase handshake).
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);

    localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        LAT4    = 4'(LATENCY);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_ack;
    logic              r_err;
    logic              r_busy;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_oor;
    logic              w_fire;
    logic              w_ram_en;
    logic              w_ram_clr;
    logic [DATA_W-1:0] w_rdata;

    // Access happens on the WAIT edge where the counter has run out; a
    // reset on that same edge cancels it so nothing is written.
    assign w_oor     = ({1'b0, r_addr} >= DEPTH_L);
    assign w_fire    = rst_n && (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_ram_en  = w_fire && !w_oor;
    assign w_ram_clr = !rst_n || (w_fire && w_oor);

    // Control FSM: state, wait counter, ack/err pulse and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_cs) begin
                        r_cnt   <= LAT4;
                        r_state <= ST_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ack   <= 1'b1;
                        r_err   <= w_oor;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!bus.mem_cs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request capture; later bus changes are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && bus.mem_cs) begin
            r_we    <= bus.mem_we;
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.mem_wdata;
        end
    end

    mem_resp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (r_we),
        .i_clr   (w_ram_clr),
        .i_addr  (r_addr[AW-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.mem_rdata = w_rdata;
    assign bus.mem_ack   = r_ack;
    assign bus.mem_err   = r_err;
    assign bus.busy      = r_busy;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 32, data width of mem_wdata/mem_rdata and each storage word; the SHALL statements below assume the default.
REQ-002 Parameter ADDR_W, default 16, width of mem_addr.
REQ-003 Parameter DEPTH, default 1024, number of storage words; the SHALL statements below assume the default.
REQ-004 Parameter LATENCY, default 2, range 0-15, wait cycles inserted before acknowledge.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 mem_cs  input  1  chip select / request from initiator, held until acknowledged.
REQ-008 mem_we  input  1  1 = write, 0 = read, qualified by mem_cs.
REQ-009 mem_addr  input  ADDR_W  word address.
REQ-010 mem_wdata  input  DATA_W  write data.
REQ-011 mem_rdata  output  DATA_W  read data, valid while mem_ack=1.
REQ-012 mem_ack  output  1  one-cycle completion pulse.
REQ-013 mem_err  output  1  out-of-range flag, valid while mem_ack=1.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, ACK, DONE; all outputs registered.
REQ-016 IDLE: on an edge with mem_cs=1 SHALL capture mem_we, mem_addr, mem_wdata, load the wait counter with LATENCY, and go to WAIT.
REQ-017 WAIT: counter nonzero -> decrement; counter zero -> perform access, set mem_ack=1, go to ACK; mem_ack thus rises exactly LATENCY+1 edges after the capture edge.
REQ-018 Inputs changing during WAIT SHALL be ignored; only captured values are used.
REQ-019 Write access (in range) SHALL commit captured mem_wdata to storage at the WAIT->ACK edge; mem_rdata SHALL return the written data (write-first).
REQ-020 Read access (in range) SHALL drive mem_rdata with the stored word at the WAIT->ACK edge.
REQ-021 Captured address >= DEPTH SHALL suppress the write, drive mem_rdata=0, mem_err=1; in range -> mem_err=0.
REQ-022 ACK: mem_ack high for exactly one cycle; next edge SHALL clear mem_ack and mem_err and go to DONE; mem_rdata holds its value until the next access.
REQ-023 DONE: SHALL stay while mem_cs=1 (four-phase handshake, no second transaction); go to IDLE on the first edge with mem_cs=0.
REQ-024 mem_cs dropping during WAIT SHALL NOT abort the access; the ack is still issued.
REQ-025 Back-to-back: a new request is accepted no earlier than the second edge after mem_cs falls (DONE->IDLE->capture).

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, mem_ack=0, mem_err=0, mem_rdata=0, busy=0, counter=0.
REQ-027 Reset during WAIT SHALL abort the transaction with no storage write.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-029 Shared package mem_if_pkg SHALL hold DATA_W/ADDR_W defaults and the FSM state encoding, reused with memory_interface.
REQ-030 Storage SHALL be a sub-module mem_resp_ram: single-port synchronous RAM, DEPTH x DATA_W, write-first, one-cycle read.

Verification
REQ-031 LATENCY=2: write 0xDEADBEEF to 0x00A0 -> mem_ack rises 3 edges after capture, one cycle wide, mem_err=0; read 0x00A0 -> mem_rdata=0xDEADBEEF.
REQ-032 Loop i=0..4: write 0xA5A50000+i to 0x0100+i, then read back -> each read returns 0xA5A50000+i.
REQ-033 Read 0x0400 -> mem_ack=1, mem_err=1, mem_rdata=0; write 0x0400 then read 0x0000 -> prior content unchanged.
REQ-034 Hold mem_cs=1 for 10 cycles after ack -> exactly one ack pulse, busy=1 until mem_cs falls.
REQ-035 Write 0x12345678 to 0x0010, assert rst_n=0 in WAIT -> no ack; read 0x0010 -> old content returned.
REQ-036 Change mem_addr to 0x0020 during WAIT of a read of 0x0010 -> data from 0x0010 returned; repeat with LATENCY=0 -> ack one edge after capture.
